// File: rtl/load_ext_unit.sv
// Load path from data memory to W stage: latches a load, waits for read data, extends byte/half/word.
// Optional misaligned-load detection is built when ADEL_CHECK_EN is defined.
module load_ext_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] instr_m,
    input  logic [1:0]  A1_0,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        w_ack,
    output logic        stall,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        bus_err,
    output logic        adel
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [1:0]       addr_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [5:0] opcode;
    logic       is_load;
    logic       misaligned;
    logic       unused_instr_bits;

    assign opcode            = instr_m[31:26];
    assign unused_instr_bits = ^instr_m[25:0];

    assign is_load = (opcode == OP_LW)  || (opcode == OP_LB) || (opcode == OP_LBU) ||
                     (opcode == OP_LH)  || (opcode == OP_LHU);

`ifdef ADEL_CHECK_EN
    assign misaligned = (((opcode == OP_LH) || (opcode == OP_LHU)) && A1_0[0]) ||
                        ((opcode == OP_LW) && (A1_0 != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // A load waiting behind an unconsumed result must also hold the pipeline.
    always_comb begin
        stall = 1'b0;
        if (state == WAIT) begin
            stall = 1'b1;
        end else if (state == DONE) begin
            stall = req_valid && is_load && !w_ack;
        end
    end

    function automatic logic [31:0] extend(input logic [5:0]  op,
                                           input logic [1:0]  addr,
                                           input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr)
            2'b00:   b = data[7:0];
            2'b01:   b = data[15:8];
            2'b10:   b = data[23:16];
            default: b = data[31:24];
        endcase
        h = addr[1] ? data[31:16] : data[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            default: r = data;
        endcase
        return r;
    endfunction

    // Data arriving on the timeout cycle takes priority over the abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= 6'd0;
            addr_q     <= 2'd0;
            wait_cnt   <= '0;
            dout       <= 32'd0;
            dout_valid <= 1'b0;
            bus_err    <= 1'b0;
            adel       <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            adel    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && is_load) begin
                        if (misaligned) begin
                            adel <= 1'b1;
                        end else begin
                            op_q     <= opcode;
                            addr_q   <= A1_0;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        dout       <= extend(op_q, addr_q, mem_rdata);
                        dout_valid <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == LAST_CNT) begin
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (w_ack) begin
                        dout_valid <= 1'b0;
                        if (req_valid && is_load) begin
                            if (misaligned) begin
                                adel  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                op_q     <= opcode;
                                addr_q   <= A1_0;
                                wait_cnt <= '0;
                                state    <= WAIT;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed self-checking bench for load_ext_unit: extension, latency, timeout, handshake and reset.
module tb_load_ext_unit;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] instr_m;
    logic [1:0]  A1_0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        w_ack;
    logic        stall;
    logic [31:0] dout;
    logic        dout_valid;
    logic        bus_err;
    logic        adel;

    int pass_cnt;
    int total_cnt;

    load_ext_unit #(.MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .instr_m    (instr_m),
        .A1_0       (A1_0),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .w_ack      (w_ack),
        .stall      (stall),
        .dout       (dout),
        .dout_valid (dout_valid),
        .bus_err    (bus_err),
        .adel       (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic issue(input logic [5:0] op, input logic [1:0] addr);
        req_valid = 1'b1;
        instr_m   = {op, 26'h1ABCDEF};
        A1_0      = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        instr_m   = 32'd0;
        A1_0      = 2'b00;
    endtask

    task automatic respond(input logic [31:0] data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    task automatic ack();
        w_ack = 1'b1;
        @(posedge clk); #1;
        w_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        req_valid  = 1'b0;
        instr_m    = 32'd0;
        A1_0       = 2'b00;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        w_ack      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({stall, dout_valid, bus_err, adel} !== 4'b0000 || dout !== 32'd0)
            $display("[TB] FAIL reset_outputs got stall=%b dv=%b be=%b adel=%b dout=%h want all zero",
                     stall, dout_valid, bus_err, adel, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_lb();
        issue(OP_LB, 2'b11);
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b1) $display("[TB] FAIL lb_stall got %b want 1", stall);
        else pass_cnt++;
        @(posedge clk); #1;
        respond(32'h80FF_1234);
        @(negedge clk);
        total_cnt++;
        if (dout !== 32'hFFFF_FF80 || dout_valid !== 1'b1 || stall !== 1'b0)
            $display("[TB] FAIL lb_result got dout=%h dv=%b stall=%b want ffffff80 1 0", dout, dout_valid, stall);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
        @(negedge clk);
        total_cnt++;
        if (dout_valid !== 1'b0 || dout !== 32'hFFFF_FF80)
            $display("[TB] FAIL lb_after_ack got dv=%b dout=%h want 0 ffffff80", dout_valid, dout);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_lhu_latency();
        int n;
        n = 0;
        issue(OP_LHU, 2'b10);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'h9ABC_5678;
            end
            @(negedge clk);
            if (stall === 1'b1) n++;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        @(negedge clk);
        total_cnt++;
        if (n != 3) $display("[TB] FAIL lhu_stall_cycles got %0d want 3", n);
        else pass_cnt++;
        total_cnt++;
        if (dout !== 32'h0000_9ABC || dout_valid !== 1'b1 || stall !== 1'b0)
            $display("[TB] FAIL lhu_result got dout=%h dv=%b stall=%b want 00009abc 1 0", dout, dout_valid, stall);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
    endtask

    task automatic test_extensions();
        logic [5:0]  ops  [6];
        logic [1:0]  adrs [6];
        logic [31:0] dats [6];
        logic [31:0] exps [6];
        ops[0] = OP_LBU; adrs[0] = 2'b01; dats[0] = 32'h1122_8344; exps[0] = 32'h0000_0083;
        ops[1] = OP_LB;  adrs[1] = 2'b01; dats[1] = 32'h1122_8344; exps[1] = 32'hFFFF_FF83;
        ops[2] = OP_LB;  adrs[2] = 2'b00; dats[2] = 32'hFFFF_FF7F; exps[2] = 32'h0000_007F;
        ops[3] = OP_LH;  adrs[3] = 2'b10; dats[3] = 32'h8001_7FFF; exps[3] = 32'hFFFF_8001;
        ops[4] = OP_LH;  adrs[4] = 2'b00; dats[4] = 32'h8001_7FFF; exps[4] = 32'h0000_7FFF;
        ops[5] = OP_LW;  adrs[5] = 2'b00; dats[5] = 32'hDEAD_BEEF; exps[5] = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], adrs[i]);
            respond(dats[i]);
            @(negedge clk);
            total_cnt++;
            if (dout !== exps[i] || dout_valid !== 1'b1)
                $display("[TB] FAIL ext_vec%0d got dout=%h dv=%b want %h 1", i, dout, dout_valid, exps[i]);
            else pass_cnt++;
            @(posedge clk); #1;
            ack();
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] held;
        held = dout;
        n = 0;
        issue(OP_LW, 2'b00);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall !== 1'b1) break;
            n++;
        end
        total_cnt++;
        if (n != 15) $display("[TB] FAIL timeout_wait_cycles got %0d want 15", n);
        else pass_cnt++;
        total_cnt++;
        if (bus_err !== 1'b1 || dout_valid !== 1'b0 || dout !== held)
            $display("[TB] FAIL timeout_pulse got be=%b dv=%b dout=%h want 1 0 %h", bus_err, dout_valid, dout, held);
        else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (bus_err !== 1'b0) $display("[TB] FAIL timeout_pulse_width got %b want 0", bus_err);
        else pass_cnt++;
        @(posedge clk); #1;
        // Data on the final allowed WAIT cycle must be taken, not aborted.
        issue(OP_LW, 2'b00);
        repeat (14) @(posedge clk);
        #1;
        respond(32'h0BAD_F00D);
        @(negedge clk);
        total_cnt++;
        if (dout_valid !== 1'b1 || bus_err !== 1'b0 || dout !== 32'h0BAD_F00D)
            $display("[TB] FAIL timeout_edge_data got dv=%b be=%b dout=%h want 1 0 0badf00d", dout_valid, bus_err, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
    endtask

    task automatic test_back_to_back();
        issue(OP_LW, 2'b00);
        respond(32'hAAAA_5555);
        req_valid = 1'b1;
        instr_m   = {OP_LB, 26'd0};
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b1 || dout_valid !== 1'b1)
            $display("[TB] FAIL b2b_hold got stall=%b dv=%b want 1 1", stall, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        instr_m = {OP_LW, 26'd0};
        w_ack   = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0 || dout_valid !== 1'b1)
            $display("[TB] FAIL b2b_still_done got stall=%b dv=%b want 0 1", stall, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        w_ack     = 1'b0;
        req_valid = 1'b0;
        instr_m   = 32'd0;
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b1 || dout_valid !== 1'b0 || dout !== 32'hAAAA_5555)
            $display("[TB] FAIL b2b_accept got stall=%b dv=%b dout=%h want 1 0 aaaa5555", stall, dout_valid, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        respond(32'h1357_9BDF);
        @(negedge clk);
        total_cnt++;
        if (dout !== 32'h1357_9BDF || dout_valid !== 1'b1)
            $display("[TB] FAIL b2b_second got dout=%h dv=%b want 13579bdf 1", dout, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
    endtask

    task automatic test_ignored();
        respond(32'hFFFF_FFFF);
        @(negedge clk);
        total_cnt++;
        if (dout_valid !== 1'b0 || stall !== 1'b0 || dout !== 32'h1357_9BDF)
            $display("[TB] FAIL idle_rvalid got dv=%b stall=%b dout=%h want 0 0 13579bdf", dout_valid, stall, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        issue(OP_SW, 2'b00);
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0) $display("[TB] FAIL non_load got stall=%b want 0", stall);
        else pass_cnt++;
        @(posedge clk); #1;
        issue(OP_LW, 2'b00);
        issue(OP_LB, 2'b11);
        respond(32'hC0DE_CAFE);
        @(negedge clk);
        total_cnt++;
        if (dout !== 32'hC0DE_CAFE) $display("[TB] FAIL wait_req_ignored got %h want c0decafe", dout);
        else pass_cnt++;
        @(posedge clk); #1;
        respond(32'h1111_2222);
        @(negedge clk);
        total_cnt++;
        if (dout !== 32'hC0DE_CAFE || dout_valid !== 1'b1)
            $display("[TB] FAIL done_rvalid got dout=%h dv=%b want c0decafe 1", dout, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
    endtask

    task automatic test_reset_mid_wait();
        issue(OP_LW, 2'b00);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (stall !== 1'b0 || dout_valid !== 1'b0 || dout !== 32'd0)
            $display("[TB] FAIL reset_in_wait got stall=%b dv=%b dout=%h want 0 0 0", stall, dout_valid, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        respond(32'h5A5A_5A5A);
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0 || dout_valid !== 1'b0 || dout !== 32'd0)
            $display("[TB] FAIL stray_rvalid got stall=%b dv=%b dout=%h want 0 0 0", stall, dout_valid, dout);
        else pass_cnt++;
        @(posedge clk); #1;
        issue(OP_LW, 2'b00);
        respond(32'h7777_8888);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (dout_valid !== 1'b0 || stall !== 1'b0)
            $display("[TB] FAIL reset_in_done got dv=%b stall=%b want 0 0", dout_valid, stall);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_misaligned();
        issue(OP_LW, 2'b10);
        @(negedge clk);
`ifdef ADEL_CHECK_EN
        total_cnt++;
        if (adel !== 1'b1 || stall !== 1'b0 || dout_valid !== 1'b0)
            $display("[TB] FAIL adel_lw got adel=%b stall=%b dv=%b want 1 0 0", adel, stall, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (adel !== 1'b0 || stall !== 1'b0)
            $display("[TB] FAIL adel_pulse got adel=%b stall=%b want 0 0", adel, stall);
        else pass_cnt++;
        @(posedge clk); #1;
`else
        total_cnt++;
        if (adel !== 1'b0 || stall !== 1'b1)
            $display("[TB] FAIL misaligned_lw got adel=%b stall=%b want 0 1", adel, stall);
        else pass_cnt++;
        @(posedge clk); #1;
        respond(32'hFEDC_BA98);
        @(negedge clk);
        total_cnt++;
        if (dout !== 32'hFEDC_BA98 || dout_valid !== 1'b1)
            $display("[TB] FAIL misaligned_word got dout=%h dv=%b want fedcba98 1", dout, dout_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        ack();
`endif
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_lb();
        test_lhu_latency();
        test_extensions();
        test_timeout();
        test_back_to_back();
        test_ignored();
        test_reset_mid_wait();
        test_misaligned();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
